// File: rtl/tlc5940_chain_driver_if.sv
// Host-side bundle for tlc5940_chain_driver: frame start/status, frame-buffer read port, XERR flag.
// Ports: start, dc_mode, xerr_clear, rd_data (host -> driver); busy, frame_done, xerr_flag, rd_addr (driver -> host).
interface tlc5940_chain_driver_if #(
   parameter int LANES   = 12,
   parameter int GS_BITS = 12,
   parameter int AW      = 4
);
   logic                     start;
   logic                     dc_mode;
   logic                     busy;
   logic                     frame_done;
   logic                     xerr_clear;
   logic                     xerr_flag;
   logic [AW-1:0]            rd_addr;
   logic [LANES*GS_BITS-1:0] rd_data;

   modport master (
      output start, dc_mode, xerr_clear, rd_data,
      input  busy, frame_done, xerr_flag, rd_addr
   );

   modport slave (
      input  start, dc_mode, xerr_clear, rd_data,
      output busy, frame_done, xerr_flag, rd_addr
   );
endinterface

// File: rtl/tlc5940_chain_driver.sv
// Serial driver for LANES parallel TLC5940 daisy-chains: frame shifter, GSCLK/BLANK PWM engine, XERR capture.
// Ports: clock, reset (sync, active-high); bus (host bundle); led_* pins to the chains; led_xerr async active-low.
module tlc5940_chain_driver #(
   parameter int LANES     = 12,
   parameter int CHIPS     = 1,
   parameter int GS_BITS   = 12,
   parameter int DC_BITS   = 6,
   parameter int SCLK_DIV  = 2,
   parameter int BLANK_LEN = 4
) (
   input  logic             clock,
   input  logic             reset,
   tlc5940_chain_driver_if.slave bus,
   output logic             led_sclk,
   output logic [LANES-1:0] led_sin,
   output logic             led_mode,
   output logic             led_blank,
   output logic             led_xlat,
   output logic             led_gsclk,
   input  logic             led_xerr
);
   localparam int NCH   = 16 * CHIPS;
   localparam int AW    = $clog2(NCH);
   localparam int BW    = $clog2(GS_BITS + 1);
   localparam int DW    = $clog2(SCLK_DIV + 1);
   localparam int KW    = $clog2(BLANK_LEN);
   localparam int DC_SH = GS_BITS - DC_BITS;
   localparam logic [DW-1:0] DIV_END = DW'(SCLK_DIV - 1);
   localparam logic [KW-1:0] K_END   = KW'(BLANK_LEN - 1);
   localparam logic [KW-1:0] K1      = KW'(1);

   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_SHIFT, S_WAIT} state_t;
   state_t state, state_nx;

   logic [AW-1:0]      ch;
   logic [DW-1:0]      div;
   logic [BW-1:0]      bit_cnt;
   logic [GS_BITS-1:0] sreg [LANES];
   logic [GS_BITS-1:0] word [LANES];
   logic [LANES-1:0]   sin_r;
   logic               sclk_r, mode_r, busy_r, done_r;
   logic               pending, loaded, latched_dc, extra, extra_sclk;
   logic               in_blank, gsclk_r, xlat_r;
   logic [KW-1:0]      k;
   logic [GS_BITS-1:0] gs_cnt;
   logic [2:0]         run_cnt;
   logic               xs1, xs2, flag_r;
   logic               div_end, shift_done, latch_fire, extra_fire, xerr_sample;

   assign div_end    = div == DIV_END;
   assign shift_done = state == S_SHIFT && sclk_r && div_end && bit_cnt == '0;
   assign latch_fire = in_blank && k == '0 && pending;
   // The post-DC extra SCLK goes out only once a GS frame has replaced the DC data.
   assign extra_fire = in_blank && k == K1 && extra && !latched_dc;
   assign xerr_sample = !led_blank && run_cnt == 3'd4;

   // DC words sit in the low bits of each slice; left-align so MSB-first shifting is shared.
   always_comb begin
      for (int l = 0; l < LANES; l++) begin
         word[l] = bus.rd_data[l*GS_BITS +: GS_BITS];
         if (mode_r) word[l] = GS_BITS'(bus.rd_data[l*GS_BITS +: DC_BITS]) << DC_SH;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE:  if (bus.start) state_nx = S_FETCH;
         S_FETCH: state_nx = S_LOAD;
         S_LOAD:  state_nx = S_SHIFT;
         S_SHIFT: if (shift_done) state_nx = (ch == '0) ? S_WAIT : S_FETCH;
         S_WAIT:  if (xlat_r) state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         mode_r     <= 1'b0;
         ch         <= AW'(NCH - 1);
         div        <= '0;
         bit_cnt    <= '0;
         sclk_r     <= 1'b0;
         sin_r      <= '0;
         pending    <= 1'b0;
         loaded     <= 1'b0;
         latched_dc <= 1'b0;
         extra      <= 1'b0;
         extra_sclk <= 1'b0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         for (int l = 0; l < LANES; l++) sreg[l] <= '0;
      end else begin
         busy_r     <= state_nx != S_IDLE;
         done_r     <= state == S_WAIT && xlat_r;
         extra_sclk <= extra_fire;
         if (latch_fire) begin
            pending    <= 1'b0;
            loaded     <= 1'b1;
            latched_dc <= mode_r;
            if (mode_r) extra <= 1'b1;
         end else if (extra_fire) begin
            extra <= 1'b0;
         end
         unique case (state)
            S_IDLE: begin
               if (bus.start) begin
                  mode_r <= bus.dc_mode;
                  ch     <= AW'(NCH - 1);
               end
            end
            S_LOAD: begin
               for (int l = 0; l < LANES; l++) begin
                  sreg[l]  <= word[l];
                  sin_r[l] <= word[l][GS_BITS-1];
               end
               bit_cnt <= mode_r ? BW'(DC_BITS - 1) : BW'(GS_BITS - 1);
               div     <= '0;
               sclk_r  <= 1'b0;
            end
            S_SHIFT: begin
               div <= div_end ? '0 : div + 1'b1;
               if (div_end && !sclk_r) begin
                  sclk_r <= 1'b1;
               end else if (div_end) begin
                  sclk_r <= 1'b0;
                  if (bit_cnt == '0) begin
                     sin_r <= '0;
                     if (ch == '0) pending <= 1'b1;
                     else          ch      <= ch - 1'b1;
                  end else begin
                     bit_cnt <= bit_cnt - 1'b1;
                     for (int l = 0; l < LANES; l++) begin
                        sreg[l]  <= sreg[l] << 1;
                        sin_r[l] <= sreg[l][GS_BITS-2];
                     end
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // PWM engine: BLANK window of BLANK_LEN cycles, then 2**GS_BITS GSCLK pulses.
   always_ff @(posedge clock) begin
      if (reset) begin
         in_blank <= 1'b1;
         k        <= '0;
         gs_cnt   <= '0;
         gsclk_r  <= 1'b0;
         xlat_r   <= 1'b0;
         run_cnt  <= '0;
      end else begin
         xlat_r <= latch_fire;
         if (in_blank) begin
            run_cnt <= '0;
            if (k == K_END) begin
               in_blank <= 1'b0;
               k        <= '0;
            end else begin
               k <= k + 1'b1;
            end
         end else begin
            gsclk_r <= !gsclk_r;
            if (run_cnt != 3'd4) run_cnt <= run_cnt + 1'b1;
            if (gsclk_r) begin
               gs_cnt <= gs_cnt + 1'b1;
               if (gs_cnt == '1) in_blank <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         xs1    <= 1'b1;
         xs2    <= 1'b1;
         flag_r <= 1'b0;
      end else begin
         xs1 <= led_xerr;
         xs2 <= xs1;
         if (bus.xerr_clear)             flag_r <= 1'b0;
         else if (xerr_sample && !xs2)  flag_r <= 1'b1;
      end
   end

   assign bus.rd_addr    = ch;
   assign bus.busy       = busy_r;
   assign bus.frame_done = done_r;
   assign bus.xerr_flag  = flag_r;
   assign led_sclk       = sclk_r | extra_sclk;
   assign led_sin        = sin_r;
   assign led_mode       = mode_r;
   assign led_blank      = in_blank | !loaded;
   assign led_xlat       = xlat_r;
   assign led_gsclk      = gsclk_r;
endmodule

// File: tb/tb_tlc5940_chain_driver.sv
// Scoreboard bench for tlc5940_chain_driver: expected SIN bits queued per frame, popped on each SCLK rise.
// Ports: drives clock/reset, the host bundle, a registered frame buffer model and led_xerr.
module tb_tlc5940_chain_driver;
   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   tlc5940_chain_driver_if #(.LANES(2), .GS_BITS(4), .AW(4)) bus ();

   logic       led_sclk, led_mode, led_blank, led_xlat, led_gsclk;
   logic [1:0] led_sin;
   logic       led_xerr = 1'b1;

   tlc5940_chain_driver #(
      .LANES(2), .CHIPS(1), .GS_BITS(4), .DC_BITS(2), .SCLK_DIV(1), .BLANK_LEN(4)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .bus       (bus),
      .led_sclk  (led_sclk),
      .led_sin   (led_sin),
      .led_mode  (led_mode),
      .led_blank (led_blank),
      .led_xlat  (led_xlat),
      .led_gsclk (led_gsclk),
      .led_xerr  (led_xerr)
   );

   // Frame buffer: lane0 = channel index, lane1 = its complement, one cycle latency.
   always @(posedge clock) bus.rd_data <= {~bus.rd_addr, bus.rd_addr};

   int n_cmp = 0;
   int n_bad = 0;
   logic [1:0] exp_q[$];

   int cyc = 0, since_gs = 0, gs_mon = 0, gs_period = 0;
   int sclk_rises = 0, rise_k = -1, xlat_cnt = 0, xlat_k = -1, xlat_cyc = 0;
   int done_gap = -1, blank_k = 0, blank_len = 0, falls = 0;
   logic mode_at_xlat = 1'b0;
   logic p_sclk = 1'b0, p_gs = 1'b0, p_blank = 1'b1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   initial begin
      forever begin
         @(negedge clock);
         cyc++;
         if (led_gsclk) since_gs = 0;
         else           since_gs++;
         if (led_gsclk && !p_gs) gs_mon++;
         if (led_sclk && !p_sclk) begin
            sclk_rises++;
            rise_k = since_gs - 1;
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL sclk_unexpected: rise with empty queue, sin=%b", led_sin);
            end else begin
               chk("sin_bits", led_sin, exp_q.pop_front());
            end
         end
         if (led_xlat) begin
            xlat_cnt++;
            xlat_k       = since_gs - 1;
            xlat_cyc     = cyc;
            mode_at_xlat = led_mode;
         end
         if (bus.frame_done) done_gap = cyc - xlat_cyc;
         if (led_blank) blank_k = p_blank ? blank_k + 1 : 0;
         if (!led_blank && p_blank) begin
            falls++;
            blank_len = blank_k + 1;
            gs_period = gs_mon;
            gs_mon    = 0;
         end
         p_sclk  = led_sclk;
         p_gs    = led_gsclk;
         p_blank = led_blank;
      end
   end

   task automatic push_frame(input bit dc);
      logic [3:0] w0, w1;
      for (int c = 15; c >= 0; c--) begin
         w0 = 4'(c);
         w1 = ~w0;
         for (int b = (dc ? 1 : 3); b >= 0; b--) exp_q.push_back({w1[b], w0[b]});
      end
   endtask

   task automatic start_frame(input logic dc);
      @(negedge clock);
      bus.start   = 1'b1;
      bus.dc_mode = dc;
      @(negedge clock);
      bus.start   = 1'b0;
      bus.dc_mode = 1'b0;
   endtask

   function automatic logic probe(input int which);
      case (which)
         0:       return bus.frame_done;
         1:       return led_blank;
         default: return bus.busy && bus.rd_addr == 4'd7;
      endcase
   endfunction

   task automatic wait_until(input int which, input logic val, input int maxc, input string nm);
      logic ok = 1'b0;
      for (int i = 0; i < maxc; i++) begin
         @(negedge clock);
         if (probe(which) == val) begin
            ok = 1'b1;
            break;
         end
      end
      chk(nm, ok, 1'b1);
   endtask

   int base, x0, f0;

   initial begin
      bus.start      = 1'b0;
      bus.dc_mode    = 1'b0;
      bus.xerr_clear = 1'b0;
      repeat (5) @(negedge clock);
      chk("rst_blank", led_blank, 1'b1);
      chk("rst_sclk", led_sclk, 1'b0);
      chk("rst_xlat", led_xlat, 1'b0);
      chk("rst_gsclk", led_gsclk, 1'b0);
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_addr", bus.rd_addr, 4'hF);
      chk("rst_xerr_flag", bus.xerr_flag, 1'b0);
      reset = 1'b0;
      repeat (100) @(negedge clock);
      chk("dark_no_fall", falls, 0);
      chk("dark_blank", led_blank, 1'b1);

      base = sclk_rises;
      push_frame(1'b0);
      start_frame(1'b0);
      chk("gs_mode", led_mode, 1'b0);
      wait_until(0, 1'b1, 500, "gs_done");
      repeat (3) @(negedge clock);
      chk("gs_sclk_count", sclk_rises - base, 64);
      chk("gs_queue_empty", exp_q.size(), 0);
      chk("gs_xlat_k", xlat_k, 1);
      chk("gs_done_gap", done_gap, 1);
      chk("gs_busy_clear", bus.busy, 1'b0);
      wait_until(1, 1'b0, 10, "gs_blank_falls");

      f0 = falls;
      for (int i = 0; i < 200 && falls < f0 + 2; i++) @(negedge clock);
      @(negedge clock);
      chk("pwm_gs_pulses", gs_period, 16);
      chk("pwm_blank_len", blank_len, 4);

      base = sclk_rises;
      push_frame(1'b1);
      start_frame(1'b1);
      repeat (5) @(negedge clock);
      chk("dc_mode_pin", led_mode, 1'b1);
      wait_until(0, 1'b1, 500, "dc_done");
      repeat (3) @(negedge clock);
      chk("dc_sclk_count", sclk_rises - base, 32);
      chk("dc_mode_at_xlat", mode_at_xlat, 1'b1);
      chk("dc_queue_empty", exp_q.size(), 0);

      base = sclk_rises;
      push_frame(1'b0);
      exp_q.push_back(2'b00);
      start_frame(1'b0);
      wait_until(0, 1'b1, 500, "gs_after_dc_done");
      repeat (3) @(negedge clock);
      chk("extra_sclk_count", sclk_rises - base, 65);
      chk("extra_sclk_k", rise_k, 2);
      chk("extra_queue_empty", exp_q.size(), 0);

      base = sclk_rises;
      push_frame(1'b0);
      start_frame(1'b0);
      wait_until(0, 1'b1, 500, "gs2_done");
      repeat (3) @(negedge clock);
      chk("no_extra_count", sclk_rises - base, 64);

      wait_until(1, 1'b0, 100, "xerr_run_1");
      repeat (10) @(negedge clock);
      led_xerr = 1'b0;
      repeat (3) @(negedge clock);
      led_xerr = 1'b1;
      repeat (5) @(negedge clock);
      chk("xerr_set", bus.xerr_flag, 1'b1);
      repeat (40) @(negedge clock);
      chk("xerr_sticky", bus.xerr_flag, 1'b1);
      bus.xerr_clear = 1'b1;
      @(negedge clock);
      bus.xerr_clear = 1'b0;
      chk("xerr_cleared", bus.xerr_flag, 1'b0);
      wait_until(1, 1'b1, 100, "xerr_blank_start");
      led_xerr = 1'b0;
      repeat (3) @(negedge clock);
      led_xerr = 1'b1;
      repeat (12) @(negedge clock);
      chk("xerr_blank_ignored", bus.xerr_flag, 1'b0);
      wait_until(1, 1'b0, 100, "xerr_run_2");
      repeat (6) @(negedge clock);
      bus.xerr_clear = 1'b1;
      led_xerr = 1'b0;
      repeat (6) @(negedge clock);
      led_xerr = 1'b1;
      repeat (3) @(negedge clock);
      bus.xerr_clear = 1'b0;
      @(negedge clock);
      chk("xerr_clear_wins", bus.xerr_flag, 1'b0);

      push_frame(1'b0);
      start_frame(1'b0);
      wait_until(2, 1'b1, 200, "reach_ch7");
      repeat (3) @(negedge clock);
      reset = 1'b1;
      exp_q.delete();
      x0 = xlat_cnt;
      f0 = falls;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      chk("mid_rst_busy", bus.busy, 1'b0);
      chk("mid_rst_blank", led_blank, 1'b1);
      repeat (200) @(negedge clock);
      chk("mid_rst_no_xlat", xlat_cnt - x0, 0);
      chk("mid_rst_no_fall", falls - f0, 0);

      base = sclk_rises;
      push_frame(1'b0);
      start_frame(1'b0);
      repeat (20) @(negedge clock);
      start_frame(1'b1);
      wait_until(0, 1'b1, 500, "busy_start_done");
      repeat (3) @(negedge clock);
      chk("busy_start_count", sclk_rises - base, 64);
      chk("busy_start_mode", mode_at_xlat, 1'b0);
      chk("busy_start_queue", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
